// File: rtl/bandeja_rolhas_pkg.sv
// Shared types and default constants for the cork tray stage.
// Default build uses the base feature set; see bandeja_rolhas.sv for BANDEJA_TIMEOUT_EN.
package bandeja_pkg;

    typedef enum logic [1:0] {
        CHEIA,
        PEDINDO,
        VAZIA,
        REPOSTA
    } estado_t;

    localparam int LARGURA_PADRAO    = 5;
    localparam int CAPACIDADE_PADRAO = 25;
    localparam int LIMIAR_PADRAO     = 5;
    localparam int LOTE_PADRAO       = 20;
    localparam int TIMEOUT_PADRAO    = 64;

endpackage

// File: rtl/bandeja_rolhas_if.sv
// Cork tray bus: sealing request, dispenser refill and tray status.
// master drives requests/refills, slave is the tray.
interface bandeja_rolhas_if #(
    parameter int LARGURA = 5
);

    logic               vedar;
    logic               reabastecer;
    logic               rolha_ok;
    logic               falta_rolha;
    logic               ativar;
    logic [LARGURA-1:0] qt_rolhas;
    logic               alarme_dispensador;

    modport master (
        output vedar,
        output reabastecer,
        input  rolha_ok,
        input  falta_rolha,
        input  ativar,
        input  qt_rolhas,
        input  alarme_dispensador
    );

    modport slave (
        input  vedar,
        input  reabastecer,
        output rolha_ok,
        output falta_rolha,
        output ativar,
        output qt_rolhas,
        output alarme_dispensador
    );

endinterface

// File: rtl/bandeja_rolhas_detector_borda.sv
// Rising-edge detector: one-cycle pulso per low-to-high transition of in.
// Shared by the bottling line stages.
module detector_borda (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulso
);

    logic in_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) in_q <= 1'b0;
        else      in_q <= in;
    end

    assign pulso = in & ~in_q;

endmodule

// File: rtl/bandeja_rolhas.sv
// Cork tray: count, saturating refill, refill-request FSM.
// Optional dispenser watchdog enabled by defining BANDEJA_TIMEOUT_EN.
module bandeja_rolhas
    import bandeja_pkg::*;
#(
    parameter int LARGURA    = LARGURA_PADRAO,
    parameter int CAPACIDADE = CAPACIDADE_PADRAO,
    parameter int LIMIAR     = LIMIAR_PADRAO,
    parameter int LOTE       = LOTE_PADRAO
`ifdef BANDEJA_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = TIMEOUT_PADRAO
`endif
) (
    input  logic             clk,
    input  logic             rst,
    bandeja_rolhas_if.slave  bus
);

    localparam int W = LARGURA + 1;
    localparam logic [W-1:0]       CAP_W = W'(CAPACIDADE);
    localparam logic [W-1:0]       LOT_W = W'(LOTE);
    localparam logic [LARGURA-1:0] CAP   = LARGURA'(CAPACIDADE);
    localparam logic [LARGURA-1:0] LIM   = LARGURA'(LIMIAR);

    estado_t            estado;
    logic [LARGURA-1:0] qt;
    logic [LARGURA-1:0] qt_n;
    logic [W-1:0]       soma;
    logic               acc_ref;
    logic               consome;
    logic               recusa;
    logic               rolha_ok_q;
    logic               falta_q;
    logic               ativar_q;
    logic               pedido;

    detector_borda u_borda (
        .clk   (clk),
        .rst   (rst),
        .in    (bus.reabastecer),
        .pulso (acc_ref)
    );

    // Wider sum so a batch on a nearly full tray saturates instead of wrapping
    always_comb begin
        consome = bus.vedar & (qt != '0);
        recusa  = bus.vedar & (qt == '0);
        soma    = {1'b0, qt};
        if (acc_ref) soma = soma + LOT_W;
        if (consome) soma = soma - W'(1);
        qt_n    = (soma > CAP_W) ? CAP : soma[LARGURA-1:0];
    end

    assign pedido = (estado == PEDINDO) || (estado == VAZIA);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qt         <= CAP;
            estado     <= CHEIA;
            rolha_ok_q <= 1'b0;
            falta_q    <= 1'b0;
            ativar_q   <= 1'b0;
        end else begin
            qt         <= qt_n;
            rolha_ok_q <= consome;
            falta_q    <= recusa;
            ativar_q   <= pedido;
            unique case (estado)
                CHEIA:
                    if (qt_n <= LIM) estado <= PEDINDO;
                PEDINDO:
                    if (acc_ref)           estado <= REPOSTA;
                    else if (qt_n == '0)   estado <= VAZIA;
                VAZIA:
                    if (acc_ref) estado <= REPOSTA;
                REPOSTA:
                    estado <= (qt_n > LIM) ? CHEIA : PEDINDO;
            endcase
        end
    end

`ifdef BANDEJA_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wd;
    logic          alarme_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd       <= '0;
            alarme_q <= 1'b0;
        end else if (pedido && !acc_ref) begin
            if (wd != WW'(TIMEOUT))     wd       <= wd + WW'(1);
            if (wd == WW'(TIMEOUT - 1)) alarme_q <= 1'b1;
        end else begin
            wd <= '0;
        end
    end

    assign bus.alarme_dispensador = alarme_q;
`else
    assign bus.alarme_dispensador = 1'b0;
`endif

    assign bus.qt_rolhas   = qt;
    assign bus.rolha_ok    = rolha_ok_q;
    assign bus.falta_rolha = falta_q;
    assign bus.ativar      = ativar_q;

endmodule

// File: tb/tb_bandeja_rolhas.sv
// Directed bench for the cork tray stage.
module tb_bandeja_rolhas;
    import bandeja_pkg::*;

`ifdef BANDEJA_TIMEOUT_EN
    localparam logic WD = 1'b1;
`else
    localparam logic WD = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bandeja_rolhas_if #(.LARGURA(5)) bus ();

    bandeja_rolhas dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.vedar = 1'b0;
        bus.reabastecer = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.qt_rolhas !== 5'd25) begin
            errors++;
            $display("FAIL reset_qt got %0d want 25", bus.qt_rolhas);
        end
        checks++;
        if ({bus.ativar, bus.rolha_ok, bus.falta_rolha,
             bus.alarme_dispensador} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000",
                {bus.ativar, bus.rolha_ok, bus.falta_rolha,
                 bus.alarme_dispensador});
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_consumo();
        for (int i = 0; i < 20; i++) begin
            bus.vedar = 1'b1;
            tick();
            checks++;
            if (bus.rolha_ok !== 1'b1 || bus.qt_rolhas !== 5'(24 - i)) begin
                errors++;
                $display("FAIL consumo_%0d got ok=%b qt=%0d want ok=1 qt=%0d",
                    i, bus.rolha_ok, bus.qt_rolhas, 24 - i);
            end
            checks++;
            if (bus.ativar !== 1'b0) begin
                errors++;
                $display("FAIL consumo_ativar_early_%0d got %b want 0",
                    i, bus.ativar);
            end
            bus.vedar = 1'b0;
            tick();
            checks++;
            if (bus.rolha_ok !== 1'b0 || bus.ativar !== (i == 19)) begin
                errors++;
                $display("FAIL consumo_idle_%0d got ok=%b ativar=%b want ok=0 ativar=%b",
                    i, bus.rolha_ok, bus.ativar, i == 19);
            end
        end
    endtask

    task automatic test_refill();
        bus.reabastecer = 1'b1;
        tick();
        checks++;
        if (bus.qt_rolhas !== 5'd25 || dut.estado !== REPOSTA) begin
            errors++;
            $display("FAIL refill_first got qt=%0d st=%0d want qt=25 st=%0d",
                bus.qt_rolhas, dut.estado, REPOSTA);
        end
        tick();
        checks++;
        if (bus.ativar !== 1'b0 || dut.estado !== CHEIA) begin
            errors++;
            $display("FAIL refill_drop got ativar=%b st=%0d want 0 st=%0d",
                bus.ativar, dut.estado, CHEIA);
        end
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (bus.qt_rolhas !== 5'd25 || bus.ativar !== 1'b0) begin
            errors++;
            $display("FAIL refill_level got qt=%0d ativar=%b want 25 0",
                bus.qt_rolhas, bus.ativar);
        end
        bus.reabastecer = 1'b0;
        tick();
    endtask

    task automatic test_vazio();
        bus.vedar = 1'b1;
        for (int i = 0; i < 25; i++) tick();
        checks++;
        if (bus.rolha_ok !== 1'b1 || bus.qt_rolhas !== 5'd0) begin
            errors++;
            $display("FAIL vazio_drain got ok=%b qt=%0d want 1 0",
                bus.rolha_ok, bus.qt_rolhas);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.falta_rolha !== 1'b1 || bus.rolha_ok !== 1'b0 ||
                bus.qt_rolhas !== 5'd0) begin
                errors++;
                $display("FAIL vazio_refuse_%0d got falta=%b ok=%b qt=%0d want 1 0 0",
                    i, bus.falta_rolha, bus.rolha_ok, bus.qt_rolhas);
            end
        end
        bus.vedar = 1'b0;
        tick();
        checks++;
        if (bus.falta_rolha !== 1'b0 || bus.ativar !== 1'b1 ||
            dut.estado !== VAZIA) begin
            errors++;
            $display("FAIL vazio_state got falta=%b ativar=%b st=%0d want 0 1 %0d",
                bus.falta_rolha, bus.ativar, dut.estado, VAZIA);
        end
    endtask

    task automatic test_simultaneo();
        bus.reabastecer = 1'b1;
        tick();
        bus.reabastecer = 1'b0;
        tick();
        bus.vedar = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        bus.vedar = 1'b0;
        tick();
        checks++;
        if (bus.qt_rolhas !== 5'd3 || dut.estado !== PEDINDO) begin
            errors++;
            $display("FAIL simul_setup got qt=%0d st=%0d want 3 %0d",
                bus.qt_rolhas, dut.estado, PEDINDO);
        end
        bus.vedar = 1'b1;
        bus.reabastecer = 1'b1;
        tick();
        checks++;
        if (bus.rolha_ok !== 1'b1 || bus.qt_rolhas !== 5'd22 ||
            dut.estado !== REPOSTA) begin
            errors++;
            $display("FAIL simul_both got ok=%b qt=%0d st=%0d want 1 22 %0d",
                bus.rolha_ok, bus.qt_rolhas, dut.estado, REPOSTA);
        end
        bus.vedar = 1'b0;
        bus.reabastecer = 1'b0;
        tick();
        checks++;
        if (dut.estado !== CHEIA || bus.qt_rolhas !== 5'd22) begin
            errors++;
            $display("FAIL simul_after got st=%0d qt=%0d want %0d 22",
                dut.estado, bus.qt_rolhas, CHEIA);
        end
    endtask

    task automatic test_nao_solicitado();
        for (int k = 0; k < 2; k++) begin
            bus.reabastecer = 1'b1;
            tick();
            checks++;
            if (bus.qt_rolhas !== 5'd25 || dut.estado !== CHEIA) begin
                errors++;
                $display("FAIL unsolicited_%0d got qt=%0d st=%0d want 25 %0d",
                    k, bus.qt_rolhas, dut.estado, CHEIA);
            end
            bus.reabastecer = 1'b0;
            tick();
            checks++;
            if (bus.ativar !== 1'b0) begin
                errors++;
                $display("FAIL unsolicited_ativar_%0d got %b want 0",
                    k, bus.ativar);
            end
        end
    endtask

    task automatic test_watchdog();
        bus.vedar = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        bus.vedar = 1'b0;
        checks++;
        if (bus.qt_rolhas !== 5'd5 || dut.estado !== PEDINDO) begin
            errors++;
            $display("FAIL wd_setup got qt=%0d st=%0d want 5 %0d",
                bus.qt_rolhas, dut.estado, PEDINDO);
        end
        for (int i = 0; i < 40; i++) tick();
        checks++;
        if (bus.alarme_dispensador !== 1'b0) begin
            errors++;
            $display("FAIL wd_early got %b want 0", bus.alarme_dispensador);
        end
        for (int i = 0; i < 30; i++) tick();
        checks++;
        if (bus.alarme_dispensador !== WD || bus.ativar !== 1'b1) begin
            errors++;
            $display("FAIL wd_alarm got alarm=%b ativar=%b want %b 1",
                bus.alarme_dispensador, bus.ativar, WD);
        end
        bus.reabastecer = 1'b1;
        tick();
        bus.reabastecer = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.alarme_dispensador !== WD || bus.ativar !== 1'b0 ||
            bus.qt_rolhas !== 5'd25) begin
            errors++;
            $display("FAIL wd_sticky got alarm=%b ativar=%b qt=%0d want %b 0 25",
                bus.alarme_dispensador, bus.ativar, bus.qt_rolhas, WD);
        end
        bus.vedar = 1'b1;
        tick();
        bus.reabastecer = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.qt_rolhas !== 5'd25 ||
            {bus.ativar, bus.rolha_ok, bus.falta_rolha,
             bus.alarme_dispensador} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset got qt=%0d flags=%b want 25 0000",
                bus.qt_rolhas,
                {bus.ativar, bus.rolha_ok, bus.falta_rolha,
                 bus.alarme_dispensador});
        end
        bus.vedar = 1'b0;
        bus.reabastecer = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_consumo();
        test_refill();
        test_vazio();
        test_simultaneo();
        test_nao_solicitado();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
